// File: rtl/fifo_ctrl.sv
// Pointer, arbitration and status control for a 2^ADDR_W-entry synchronous FIFO.
// Two producers share the RAM write port round-robin; one consumer reads.
module fifo_ctrl #(
  parameter int ADDR_W    = 8,
  parameter int AFULL_TH  = 240,
  parameter int AEMPTY_TH = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              FLUSH,
  input  logic              WR_REQ0,
  input  logic              WR_REQ1,
  output logic              WR_GNT0,
  output logic              WR_GNT1,
  output logic              WR_SEL,
  input  logic              RD_EN,
  output logic              MEM_WE,
  output logic              MEM_RE,
  output logic [ADDR_W-1:0] WR_ADDR,
  output logic [ADDR_W-1:0] RD_ADDR,
  output logic              RD_VALID,
  output logic              Full,
  output logic              Empty,
  output logic              AFull,
  output logic              AEmpty,
  output logic [ADDR_W:0]   Count,
  output logic              UDF,
  input  logic              CLR_ERR
);

  localparam int PW = ADDR_W + 1;

  typedef enum logic {
    PRI_REQ0 = 1'b0,
    PRI_REQ1 = 1'b1
  } pri_t;

  pri_t          pri_q, pri_d;
  logic [PW-1:0] wr_ptr, rd_ptr, wr_ptr_d, rd_ptr_d;
  logic          rd_valid_q, rd_valid_d;
  logic          udf_q, udf_d;
  logic          wr_ok;

  always_comb begin
    Empty   = (wr_ptr == rd_ptr);
    Full    = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
              (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
    Count   = wr_ptr - rd_ptr;
    AFull   = (Count >= PW'(AFULL_TH));
    AEmpty  = (Count <= PW'(AEMPTY_TH));
    WR_ADDR = wr_ptr[ADDR_W-1:0];
    RD_ADDR = rd_ptr[ADDR_W-1:0];
  end

  // Requests are masked while reset is held so outputs show idle immediately.
  always_comb begin
    wr_ok   = RST && !Full && !FLUSH;
    WR_GNT0 = wr_ok && WR_REQ0 && (!WR_REQ1 || (pri_q == PRI_REQ0));
    WR_GNT1 = wr_ok && WR_REQ1 && (!WR_REQ0 || (pri_q == PRI_REQ1));
    WR_SEL  = WR_GNT1;
    MEM_WE  = WR_GNT0 || WR_GNT1;
    MEM_RE  = RST && RD_EN && !Empty && !FLUSH;
  end

  always_comb begin
    pri_d      = pri_q;
    wr_ptr_d   = wr_ptr;
    rd_ptr_d   = rd_ptr;
    rd_valid_d = 1'b0;
    udf_d      = (udf_q && !CLR_ERR) || (RD_EN && Empty);
    if (FLUSH) begin
      pri_d    = PRI_REQ0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (WR_GNT0)
        pri_d = PRI_REQ1;
      else if (WR_GNT1)
        pri_d = PRI_REQ0;
      if (MEM_WE)
        wr_ptr_d = wr_ptr + PW'(1);
      if (MEM_RE)
        rd_ptr_d = rd_ptr + PW'(1);
      rd_valid_d = MEM_RE;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      pri_q      <= PRI_REQ0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      rd_valid_q <= 1'b0;
      udf_q      <= 1'b0;
    end else begin
      pri_q      <= pri_d;
      wr_ptr     <= wr_ptr_d;
      rd_ptr     <= rd_ptr_d;
      rd_valid_q <= rd_valid_d;
      udf_q      <= udf_d;
    end
  end

  assign RD_VALID = rd_valid_q;
  assign UDF      = udf_q;

endmodule

// File: tb/tb_fifo_ctrl.sv
// Self-checking bench for fifo_ctrl: directed vector table, corner sequences,
// and randomized traffic against an occupancy/queue reference model.
module tb_fifo_ctrl;

  localparam int AW    = 8;
  localparam int DEPTH = 256;
  localparam int AFT   = 240;
  localparam int AET   = 16;

  logic          CLK = 1'b0;
  logic          RST, FLUSH, WR_REQ0, WR_REQ1, RD_EN, CLR_ERR;
  logic          WR_GNT0, WR_GNT1, WR_SEL, MEM_WE, MEM_RE, RD_VALID;
  logic          Full, Empty, AFull, AEmpty, UDF;
  logic [AW-1:0] WR_ADDR, RD_ADDR;
  logic [AW:0]   Count;

  int total = 0;
  int bad   = 0;

  // Reference model: totals of accepted writes/reads and a queue of addresses.
  int   m_wr, m_rd;
  bit   m_pri, m_rv, m_udf;
  int   addr_q[$];
  int   occ;
  bit   e_full, e_empty, e_g0, e_g1, e_re;

  typedef struct {
    logic fl, r0, r1, rd, clr;
    logic g0, g1, re, em, rv, udf;
    int   cnt;
  } vec_t;

  vec_t tbl[20];

  fifo_ctrl #(.ADDR_W(AW), .AFULL_TH(AFT), .AEMPTY_TH(AET)) dut (
    .CLK(CLK), .RST(RST), .FLUSH(FLUSH),
    .WR_REQ0(WR_REQ0), .WR_REQ1(WR_REQ1),
    .WR_GNT0(WR_GNT0), .WR_GNT1(WR_GNT1), .WR_SEL(WR_SEL),
    .RD_EN(RD_EN), .MEM_WE(MEM_WE), .MEM_RE(MEM_RE),
    .WR_ADDR(WR_ADDR), .RD_ADDR(RD_ADDR), .RD_VALID(RD_VALID),
    .Full(Full), .Empty(Empty), .AFull(AFull), .AEmpty(AEmpty),
    .Count(Count), .UDF(UDF), .CLR_ERR(CLR_ERR)
  );

  always #5 CLK = ~CLK;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    m_wr = 0; m_rd = 0; m_pri = 0; m_rv = 0; m_udf = 0;
    addr_q.delete();
  endtask

  task automatic modelEval();
    occ     = m_wr - m_rd;
    e_full  = (occ == DEPTH);
    e_empty = (occ == 0);
    e_g0    = RST && !e_full && !FLUSH && WR_REQ0 && (!WR_REQ1 || !m_pri);
    e_g1    = RST && !e_full && !FLUSH && WR_REQ1 && (!WR_REQ0 || m_pri);
    e_re    = RST && RD_EN && !e_empty && !FLUSH;
  endtask

  task automatic modelCommit();
    bit udf_n;
    udf_n = (m_udf && !CLR_ERR) || (RD_EN && e_empty);
    if (FLUSH) begin
      m_wr = 0; m_rd = 0; m_pri = 0; m_rv = 0;
      addr_q.delete();
    end else begin
      if (e_g0 || e_g1) begin
        addr_q.push_back(m_wr % DEPTH);
        m_wr++;
        m_pri = e_g0;
      end
      if (e_re) begin
        void'(addr_q.pop_front());
        m_rd++;
      end
      m_rv = e_re;
    end
    m_udf = udf_n;
  endtask

  task automatic applyStimulus(input logic fl, r0, r1, rd, clr);
    FLUSH = fl; WR_REQ0 = r0; WR_REQ1 = r1; RD_EN = rd; CLR_ERR = clr;
    @(negedge CLK);
  endtask

  task automatic checkOutput();
    modelEval();
    cmp("gnt0", WR_GNT0, e_g0);
    cmp("gnt1", WR_GNT1, e_g1);
    cmp("wr_sel", WR_SEL, e_g1);
    cmp("mem_we", MEM_WE, e_g0 || e_g1);
    cmp("mem_re", MEM_RE, e_re);
    cmp("wr_addr", WR_ADDR, m_wr % DEPTH);
    cmp("rd_addr", RD_ADDR, (addr_q.size() > 0) ? addr_q[0] : (m_rd % DEPTH));
    cmp("rd_valid", RD_VALID, m_rv);
    cmp("full", Full, e_full);
    cmp("empty", Empty, e_empty);
    cmp("afull", AFull, occ >= AFT);
    cmp("aempty", AEmpty, occ <= AET);
    cmp("count", Count, occ);
    cmp("udf", UDF, m_udf);
  endtask

  task automatic endCycle();
    @(posedge CLK);
    modelCommit();
    #1;
  endtask

  task automatic cycle(input logic fl, r0, r1, rd, clr);
    applyStimulus(fl, r0, r1, rd, clr);
    checkOutput();
    endCycle();
  endtask

  task automatic doReset();
    RST = 1'b0;
    FLUSH = 0; WR_REQ0 = 0; WR_REQ1 = 0; RD_EN = 0; CLR_ERR = 0;
    modelReset();
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b1;
  endtask

  initial begin
    int grants, afull_cnt, maxcnt, wb, rb;

    // fl r0 r1 rd clr | g0 g1 re em rv udf | cnt
    tbl[0]  = '{0,1,1,0,0, 1,0,0,1,0,0, 0};
    tbl[1]  = '{0,1,1,0,0, 0,1,0,0,0,0, 1};
    tbl[2]  = '{0,1,1,0,0, 1,0,0,0,0,0, 2};
    tbl[3]  = '{0,1,1,0,0, 0,1,0,0,0,0, 3};
    tbl[4]  = '{0,1,1,0,0, 1,0,0,0,0,0, 4};
    tbl[5]  = '{0,1,1,0,0, 0,1,0,0,0,0, 5};
    tbl[6]  = '{0,0,1,0,0, 0,1,0,0,0,0, 6};
    tbl[7]  = '{0,0,1,0,0, 0,1,0,0,0,0, 7};
    tbl[8]  = '{0,1,1,0,0, 1,0,0,0,0,0, 8};
    tbl[9]  = '{0,0,0,1,0, 0,0,1,0,0,0, 9};
    tbl[10] = '{0,0,0,0,0, 0,0,0,0,1,0, 8};
    tbl[11] = '{1,1,1,1,0, 0,0,0,0,0,0, 8};
    tbl[12] = '{0,1,1,1,0, 1,0,0,1,0,0, 0};
    tbl[13] = '{0,0,0,1,0, 0,0,1,0,0,1, 1};
    tbl[14] = '{0,0,0,0,1, 0,0,0,1,1,1, 0};
    tbl[15] = '{0,0,0,0,0, 0,0,0,1,0,0, 0};
    tbl[16] = '{0,0,0,1,1, 0,0,0,1,0,0, 0};
    tbl[17] = '{0,0,0,0,0, 0,0,0,1,0,1, 0};
    tbl[18] = '{0,0,0,0,1, 0,0,0,1,0,1, 0};
    tbl[19] = '{0,0,0,0,0, 0,0,0,1,0,0, 0};

    RST = 1'b0;
    FLUSH = 0; WR_REQ0 = 0; WR_REQ1 = 0; RD_EN = 0; CLR_ERR = 0;
    modelReset();
    #2;
    cmp("rst_empty", Empty, 1);
    cmp("rst_aempty", AEmpty, 1);
    cmp("rst_full", Full, 0);
    cmp("rst_count", Count, 0);
    doReset();

    $display("[TB] vector table");
    for (int i = 0; i < 20; i++) begin
      applyStimulus(tbl[i].fl, tbl[i].r0, tbl[i].r1, tbl[i].rd, tbl[i].clr);
      checkOutput();
      cmp("tbl_gnt0", WR_GNT0, tbl[i].g0);
      cmp("tbl_gnt1", WR_GNT1, tbl[i].g1);
      cmp("tbl_mem_re", MEM_RE, tbl[i].re);
      cmp("tbl_empty", Empty, tbl[i].em);
      cmp("tbl_rd_valid", RD_VALID, tbl[i].rv);
      cmp("tbl_udf", UDF, tbl[i].udf);
      cmp("tbl_count", Count, tbl[i].cnt);
      endCycle();
    end

    $display("[TB] fill to full");
    doReset();
    grants = 0; afull_cnt = -1;
    for (int i = 0; i < 260; i++) begin
      applyStimulus(0, 1, 0, 0, 0);
      checkOutput();
      if (WR_GNT0) begin
        cmp("fill_addr", WR_ADDR, grants);
        grants++;
      end
      if (AFull && afull_cnt < 0) afull_cnt = Count;
      endCycle();
    end
    cmp("fill_grants", grants, 256);
    cmp("afull_first", afull_cnt, 240);
    cmp("fill_full", Full, 1);
    cmp("fill_count", Count, 256);

    $display("[TB] read+write at full");
    applyStimulus(0, 1, 0, 1, 0);
    checkOutput();
    cmp("atfull_gnt", WR_GNT0, 0);
    cmp("atfull_re", MEM_RE, 1);
    endCycle();
    for (int i = 0; i < 2; i++) begin
      applyStimulus(0, 1, 0, 1, 0);
      checkOutput();
      cmp("rw_count", Count, 255);
      cmp("rw_gnt", WR_GNT0, 1);
      cmp("rw_rd_valid", RD_VALID, 1);
      endCycle();
    end
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput();
    cmp("rw_count_end", Count, 255);
    cmp("rw_rd_valid_end", RD_VALID, 1);
    endCycle();

    $display("[TB] pointer wrap");
    doReset();
    maxcnt = 0;
    for (int i = 0; i < 601; i++) begin
      applyStimulus(0, 1, 0, 1, 0);
      checkOutput();
      if (int'(Count) > maxcnt) maxcnt = Count;
      endCycle();
    end
    cmp("wrap_maxcount", maxcnt, 1);
    cmp("wrap_rdaddr", RD_ADDR, 600 % DEPTH);

    $display("[TB] flush and async reset");
    doReset();
    for (int i = 0; i < 102; i++) cycle(0, 1, 0, 0, 0);
    cycle(0, 0, 0, 1, 0);
    cycle(0, 0, 0, 1, 0);
    applyStimulus(1, 1, 1, 1, 0);
    checkOutput();
    cmp("flush_count", Count, 100);
    cmp("flush_gnt0", WR_GNT0, 0);
    cmp("flush_gnt1", WR_GNT1, 0);
    cmp("flush_re", MEM_RE, 0);
    cmp("flush_rd_valid", RD_VALID, 1);
    endCycle();
    applyStimulus(0, 1, 1, 0, 0);
    checkOutput();
    cmp("post_flush_count", Count, 0);
    cmp("post_flush_empty", Empty, 1);
    cmp("post_flush_pri", WR_GNT0, 1);
    endCycle();
    cycle(0, 0, 0, 1, 0);
    cycle(0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) cycle(0, 1, 0, 0, 0);
    WR_REQ0 = 1; RD_EN = 1;
    #2;
    RST = 1'b0;
    #1;
    cmp("arst_gnt0", WR_GNT0, 0);
    cmp("arst_we", MEM_WE, 0);
    cmp("arst_re", MEM_RE, 0);
    cmp("arst_count", Count, 0);
    cmp("arst_empty", Empty, 1);
    cmp("arst_full", Full, 0);
    cmp("arst_afull", AFull, 0);
    cmp("arst_aempty", AEmpty, 1);
    cmp("arst_udf", UDF, 0);
    cmp("arst_rd_valid", RD_VALID, 0);
    doReset();

    $display("[TB] random traffic");
    for (int ph = 0; ph < 6; ph++) begin
      wb = (ph % 2 == 0) ? 90 : 30;
      rb = (ph % 2 == 0) ? 25 : 85;
      for (int i = 0; i < 500; i++) begin
        cycle($urandom_range(0, 199) == 0,
              $urandom_range(0, 99) < wb,
              $urandom_range(0, 99) < wb,
              $urandom_range(0, 99) < rb,
              $urandom_range(0, 19) == 0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_ctrl.md
# fifo_ctrl

Control block for the 256-entry synchronous FIFO. It owns the write and read pointers and shares the single memory write port between two write requesters using round-robin arbitration. It also drives the memory write/read strobes and addresses and produces the full/empty/almost/count status. It sits between the two producer interfaces, the consumer, and the dual-port RAM, and replaces the free-standing pointer registers.

## Interface
- ADDR_W, 8, memory address width; depth = 2^ADDR_W; pointers are ADDR_W+1 bits (extra wrap bit).
- AFULL_TH, 240, AFull asserts when Count >= AFULL_TH.
- AEMPTY_TH, 16, AEmpty asserts when Count <= AEMPTY_TH.

- CLK  in  1  clock, all state updates on rising edge.
- RST  in  1  reset, asynchronous, active-low.
- FLUSH  in  1  synchronous clear of pointers, arbitration state and RD_VALID.
- WR_REQ0, WR_REQ1  in  1 each  write requests from producer 0 and producer 1.
- WR_GNT0, WR_GNT1  out  1 each  combinational grants; at most one is high; a grant means the write is accepted this cycle.
- WR_SEL  out  1  index of the granted requester (data mux select); 0 when there is no grant.
- RD_EN  in  1  consumer read request.
- MEM_WE  out  1  memory write strobe = WR_GNT0 | WR_GNT1.
- MEM_RE  out  1  memory read strobe = RD_EN & ~Empty & ~FLUSH.
- WR_ADDR, RD_ADDR  out  ADDR_W each  low bits of WR_PTR and RD_PTR.
- RD_VALID  out  1  registered; read data valid one cycle after MEM_RE.
- Full, Empty, AFull, AEmpty  out  1 each  status, combinational from registered pointers.
- Count  out  ADDR_W+1  occupancy, 0..2^ADDR_W.
- UDF  out  1  sticky underflow error.
- CLR_ERR  in  1  synchronous clear of UDF.

## Operation
- Reset (RST low): WR_PTR = 0, RD_PTR = 0, priority = requester 0, RD_VALID = 0, UDF = 0. Resulting outputs: Empty = 1, AEmpty = 1, Full = 0, AFull = 0, Count = 0, no grants, MEM_WE = 0, MEM_RE = 0.
- Flag definitions:
  - Empty: WR_PTR == RD_PTR.
  - Full: MSBs of the two pointers differ and the low ADDR_W bits are equal.
  - Count: (WR_PTR − RD_PTR) mod 2^(ADDR_W+1).
- Arbitration (only when ~Full & ~FLUSH):
  - If only one requester is high, it is granted.
  - If both are high, the requester that holds priority is granted.
  - After any grant, priority moves to the other requester.
  - With no grant, priority is held.
  - When Full, both grants are 0 and priority is held.
- Write: on MEM_WE, WR_PTR increments by 1 and wraps from 2^(ADDR_W+1)−1 to 0.
- Read: on MEM_RE, RD_PTR increments by 1 with the same wrap. RD_VALID is set next cycle to the registered value of MEM_RE.
- Simultaneous read and write are both performed when the flags permit. Count is unchanged.
  - At Full, a read in the same cycle does not enable a write; the write waits one cycle.
  - At Empty, a write in the same cycle is not readable; there is no fall-through.
- Underflow: RD_EN & Empty sets UDF. The pointer does not move and RD_VALID stays 0. UDF stays set until CLR_ERR or reset. If CLR_ERR and a new underflow occur in the same cycle, UDF remains set.
- FLUSH (priority over everything except RST):
  - Next cycle: pointers = 0, priority = 0, RD_VALID = 0. UDF is unaffected.
  - No grants and no MEM_RE in the FLUSH cycle.
  - A read issued the cycle before FLUSH still produces RD_VALID in the FLUSH cycle.

## Timing
- Grant, MEM_WE, MEM_RE and addresses are combinational within the request cycle. WR_ADDR and RD_ADDR show the current pointer, i.e. the location written or read this cycle.
- Pointer, flag and Count updates are visible one cycle after the accepted operation.
- Read latency: MEM_RE in cycle N → RD_VALID high in cycle N+1, with RAM data valid in that same cycle.
- RST assertion mid-operation clears all state immediately (asynchronous). The first accepted operation happens on the first rising edge after RST deasserts.
- Sustained throughput is one write and one read per cycle.

## Test plan
- Reset, then WR_REQ0 held for 260 cycles → 256 grants with WR_ADDR 0..255. Full = 1 and Count = 256 after the 256th grant. AFull is first high at Count = 240. Grants are 0 for the remaining 4 cycles.
- WR_REQ0 = WR_REQ1 = 1 for 6 cycles from reset → grant sequence 0,1,0,1,0,1. Then WR_REQ1 only for 2 cycles → grants 1,1, and priority ends on 0.
- Fill to Full, then RD_EN and WR_REQ0 together for 3 cycles:
  - Cycle 1: read only; Count goes to 255.
  - Cycles 2–3: read and write together; Count stays 255.
  - RD_VALID follows each read by one cycle.
- From Empty, RD_EN = 1 for one cycle → MEM_RE = 0, RD_VALID = 0, UDF = 1. UDF stays 1 until CLR_ERR is pulsed, then reads 0.
- Drive 600 write/read pairs → pointers wrap 511 → 0. Count never exceeds 1 and Empty/Full are correct across the wrap.
- Count = 100 with reads in progress, then FLUSH for one cycle → next cycle Count = 0, Empty = 1, priority = 0, no grants during FLUSH. Then assert RST mid-write → all outputs at reset values immediately, without waiting for a clock edge.
